pixel_fifo: RTL

PIXEL_FIFO -- requirements
Module: pixel_fifo

---
 rtl/pixel_fifo.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pixel_fifo.sv
// ---------------------------------------------------------------------------
// pixel_fifo
//
// Purpose
//   Show-ahead circular FIFO that decouples a pixel drawing stage from a VGA
//   adapter. Each entry holds {x, y, colour}. The head entry is always
//   presented on x_out/y_out/colour_out and qualified by plot.
//
// Configuration
//   PIXEL_FIFO_CLIP_EN (macro) - when defined, writes outside the screen
//   bounds (x_in >= X_SCREEN_PIXELS or y_in >= Y_SCREEN_PIXELS) are refused
//   and reported on dropped without setting overflow.
//
// Parameters
//   DEPTH            storage entries (power of two, 4..64)
//   X_SCREEN_PIXELS  horizontal clip bound
//   Y_SCREEN_PIXELS  vertical clip bound
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-high reset
//   wr_en      in   pixel write strobe
//   x_in       in   [7:0] pixel x
//   y_in       in   [6:0] pixel y
//   colour_in  in   [2:0] pixel colour
//   rd_ready   in   adapter accepts head pixel this cycle
//   x_out      out  [7:0] head x
//   y_out      out  [6:0] head y
//   colour_out out  [2:0] head colour
//   plot       out  head entry valid
//   full       out  no free entries
//   count      out  occupancy
//   overflow   out  sticky: a write was lost because the FIFO was full
//   dropped    out  one-cycle pulse per write not stored
// ---------------------------------------------------------------------------
module pixel_fifo #(
    parameter int DEPTH           = 16,
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [7:0]                 x_in,
    input  logic [6:0]                 y_in,
    input  logic [2:0]                 colour_in,
    input  logic                       rd_ready,
    output logic [7:0]                 x_out,
    output logic [6:0]                 y_out,
    output logic [2:0]                 colour_out,
    output logic                       plot,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 18;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          plot_r;
    logic          full_r;
    logic          overflow_r;
    logic          dropped_r;

    logic          accept_s;
    logic          pop_s;
    logic          push_s;
    logic [CW-1:0] count_next_s;
    logic [EW-1:0] head_s;

    // Screen-bound acceptance of the incoming pixel
`ifdef PIXEL_FIFO_CLIP_EN
    localparam logic [8:0] X_LIM = 9'(X_SCREEN_PIXELS);
    localparam logic [7:0] Y_LIM = 8'(Y_SCREEN_PIXELS);

    always_comb begin
        accept_s = 1'b0;
        if (({1'b0, x_in} < X_LIM) && ({1'b0, y_in} < Y_LIM)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end
`else
    assign accept_s = 1'b1;
`endif

    // A full FIFO can still take a write when the head leaves on the same edge
    assign pop_s  = plot_r & rd_ready;
    assign push_s = wr_en & accept_s & (~full_r | pop_s);

    // Next occupancy from the push/pop pair
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, occupancy and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            plot_r     <= 1'b0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            dropped_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r   <= count_next_s;
            plot_r    <= (count_next_s != {CW{1'b0}});
            full_r    <= (count_next_s == DEPTH_C);
            dropped_r <= wr_en & ~push_s;
            // Clipped writes are refused before capacity is considered, so
            // only an in-bounds write against a full FIFO counts as overflow.
            if (wr_en & accept_s & full_r & ~pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Storage array; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem[wr_ptr_r] <= {x_in, y_in, colour_in};
        end
    end

    assign head_s = mem[rd_ptr_r];

    // Head data is masked while empty so stale storage never reaches the adapter
    assign x_out      = plot_r ? head_s[17:10] : 8'd0;
    assign y_out      = plot_r ? head_s[9:3]   : 7'd0;
    assign colour_out = plot_r ? head_s[2:0]   : 3'd0;
    assign plot       = plot_r;
    assign full       = full_r;
    assign count      = count_r;
    assign overflow   = overflow_r;
    assign dropped    = dropped_r;

endmodule
